approx_seq_divider: RTL and testbench

- Parametrised, multi-cycle successor to the combinational 2N/N triangular restoring array divider.
- Evaluates ROWS_PER_CYCLE restoring rows per clock, MSB row first, so one row slice of hardware is reused across cycles.
- Approximate subtractor cells are confined to a configurable lower-left triangle.
- Adds a valid/ready handshake on both sides, plus divide-by-zero and quotient-overflow flags.
- Used by the approximate-divider characterisation flow (pwr-mse sweeps) as the area-optimised variant.

---
 rtl/approx_seq_divider.sv | 196 +++++++++++++++++++
 tb/tb_approx_seq_divider.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_seq_divider.sv
// Multi-cycle 2N/N restoring divider with approximate subtractor cells in the lower-left triangle.
// ROWS_PER_CYCLE quotient rows are resolved per clock, MSB row first, behind valid/ready handshakes.
module approx_seq_divider #(
  parameter int N              = 8,
  parameter int APPROX_K       = 6,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   n,
  input  logic [N-1:0]     d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     q,
  output logic [N-1:0]     r,
  output logic             dbz,
  output logic             ovf
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] TOP_ROW    = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_SLICE = IDX_W'(ROWS_PER_CYCLE - 1);
  localparam logic [IDX_W-1:0] ROW_STEP   = IDX_W'(ROWS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    BUSY_S = 2'd1,
    DONE_S = 2'd2
  } state_e;

  state_e             state_r;
  state_e             state_next_s;
  logic [N-1:0]       rem_r;
  logic [N-1:0]       lo_r;
  logic [N-1:0]       div_r;
  logic [N-1:0]       qacc_r;
  logic [IDX_W-1:0]   row_r;
  logic               dbz_acc_r;
  logic               ovf_acc_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [N-1:0]       q_r;
  logic [N-1:0]       r_r;
  logic               dbz_r;
  logic               ovf_r;

  logic [N-1:0]       rem_s;
  logic [N-1:0]       qacc_s;
  logic [N:0]         row_res_s;
  logic [IDX_W-1:0]   idx_s;

  // One restoring row: returns {quotient bit, next partial remainder}.
  function automatic logic [N:0] row_eval(
    input logic [N-1:0] rem_prev,
    input logic         nbit,
    input logic [N-1:0] dv,
    input int           row
  );
    logic [N-1:0] p;
    logic [N-1:0] diff;
    logic         bin;
    logic         qbit;
    p    = {rem_prev[N-2:0], nbit};
    diff = {N{1'b0}};
    bin  = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (row + j < APPROX_K) begin
        diff[j] = p[j] & ~dv[j] & ~bin;
        bin     = ~p[j] & dv[j];
      end else begin
        diff[j] = p[j] ^ dv[j] ^ bin;
        bin     = (~p[j] & dv[j]) | (~(p[j] ^ dv[j]) & bin);
      end
    end
    qbit = rem_prev[N-1] | ~bin;
    return {qbit, (qbit ? diff : p)};
  endfunction

  // Row slice: chains ROWS_PER_CYCLE rows starting at the current row index.
  always_comb begin
    rem_s     = rem_r;
    qacc_s    = qacc_r;
    row_res_s = {(N+1){1'b0}};
    idx_s     = row_r;
    for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
      idx_s         = row_r - IDX_W'(k);
      row_res_s     = row_eval(rem_s, lo_r[idx_s], div_r, int'(idx_s));
      qacc_s[idx_s] = row_res_s[N];
      rem_s         = row_res_s[N-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE_S: begin
        if (in_valid && in_ready_r) begin
          state_next_s = BUSY_S;
        end else begin
          state_next_s = IDLE_S;
        end
      end
      BUSY_S: begin
        if (row_r == LAST_SLICE) begin
          state_next_s = DONE_S;
        end else begin
          state_next_s = BUSY_S;
        end
      end
      DONE_S: begin
        if (out_valid_r && out_ready) begin
          state_next_s = IDLE_S;
        end else begin
          state_next_s = DONE_S;
        end
      end
      default: state_next_s = IDLE_S;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE_S;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Working registers and registered result/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r       <= {N{1'b0}};
      lo_r        <= {N{1'b0}};
      div_r       <= {N{1'b0}};
      qacc_r      <= {N{1'b0}};
      row_r       <= {IDX_W{1'b0}};
      dbz_acc_r   <= 1'b0;
      ovf_acc_r   <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_r         <= {N{1'b0}};
      r_r         <= {N{1'b0}};
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      in_ready_r <= (state_next_s == IDLE_S);
      case (state_r)
        IDLE_S: begin
          if (in_valid && in_ready_r) begin
            rem_r     <= n[2*N-1:N];
            lo_r      <= n[N-1:0];
            div_r     <= d;
            qacc_r    <= {N{1'b0}};
            row_r     <= TOP_ROW;
            dbz_acc_r <= (d == {N{1'b0}});
            ovf_acc_r <= (n[2*N-1:N] >= d);
          end
        end
        BUSY_S: begin
          rem_r  <= rem_s;
          qacc_r <= qacc_s;
          if (row_r != LAST_SLICE) begin
            row_r <= row_r - ROW_STEP;
          end
        end
        DONE_S: begin
          // Results are published one cycle after the last row settles.
          if (!out_valid_r) begin
            q_r         <= qacc_r;
            r_r         <= rem_r;
            dbz_r       <= dbz_acc_r;
            ovf_r       <= ovf_acc_r;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign q         = q_r;
  assign r         = r_r;
  assign dbz       = dbz_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_approx_seq_divider.sv
// Randomized self-checking bench: three divider configurations run in lockstep and are
// compared against an arithmetic reference model of the approximate restoring array.
module tb_approx_seq_divider;

  localparam int N    = 8;
  localparam int NDUT = 3;
  localparam int K_TAB   [NDUT] = '{0, 6, 0};
  localparam int LAT_TAB [NDUT] = '{9, 9, 5};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] n;
  logic [7:0]  d;

  logic        in_ready_o  [NDUT];
  logic        out_valid_o [NDUT];
  logic [7:0]  q_o         [NDUT];
  logic [7:0]  r_o         [NDUT];
  logic        dbz_o       [NDUT];
  logic        ovf_o       [NDUT];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  approx_seq_divider #(.N(8), .APPROX_K(0), .ROWS_PER_CYCLE(1)) u_k0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[0]), .n(n), .d(d),
    .out_valid(out_valid_o[0]), .out_ready(out_ready), .q(q_o[0]), .r(r_o[0]),
    .dbz(dbz_o[0]), .ovf(ovf_o[0]));

  approx_seq_divider #(.N(8), .APPROX_K(6), .ROWS_PER_CYCLE(1)) u_k6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[1]), .n(n), .d(d),
    .out_valid(out_valid_o[1]), .out_ready(out_ready), .q(q_o[1]), .r(r_o[1]),
    .dbz(dbz_o[1]), .ovf(ovf_o[1]));

  approx_seq_divider #(.N(8), .APPROX_K(0), .ROWS_PER_CYCLE(2)) u_r2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[2]), .n(n), .d(d),
    .out_valid(out_valid_o[2]), .out_ready(out_ready), .q(q_o[2]), .r(r_o[2]),
    .dbz(dbz_o[2]), .ovf(ovf_o[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: per row, the approximate low columns are evaluated bitwise and the exact
  // upper columns as an integer subtraction with the approximate region's borrow.
  function automatic void model_div(input logic [15:0] nn, input logic [7:0] dd, input int k,
                                    output logic [7:0] qq, output logic [7:0] rr);
    int rem, p, e, m, bv, dlo, dhi, bin_m, hi, brw, qb, dv;
    dv  = int'(dd);
    rem = int'(nn[15:8]);
    qq  = 8'h00;
    for (int i = N - 1; i >= 0; i--) begin
      p = ((rem << 1) | int'(nn[i])) & 255;
      e = (rem >> 7) & 1;
      m = k - i;
      if (m < 0) m = 0;
      if (m > N) m = N;
      bv    = ((~p & dv) << 1) & 255;
      dlo   = p & ~dv & ~bv & ((1 << m) - 1);
      bin_m = (m == 0) ? 0 : (((~p & dv) >> (m - 1)) & 1);
      if (m < N) begin
        hi  = (p >> m) - (dv >> m) - bin_m;
        brw = (hi < 0) ? 1 : 0;
        dhi = (hi & ((1 << (N - m)) - 1)) << m;
      end else begin
        brw = bin_m;
        dhi = 0;
      end
      qb    = (e != 0 || brw == 0) ? 1 : 0;
      qq[i] = qb[0];
      rem   = (qb != 0) ? (dlo | dhi) : p;
    end
    rr = rem[7:0];
  endfunction

  task automatic run_op(input logic [15:0] nn, input logic [7:0] dd, input int hold, input string tag);
    int         lat [NDUT];
    bit         all_done;
    logic [7:0] eq;
    logic [7:0] er;
    for (int u = 0; u < NDUT; u++) begin
      check_val($sformatf("%s_u%0d_in_ready_idle", tag, u), in_ready_o[u], 1);
      lat[u] = 0;
    end
    n = nn;
    d = dd;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int u = 0; u < NDUT; u++) begin
      check_val($sformatf("%s_u%0d_in_ready_busy", tag, u), in_ready_o[u], 0);
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      all_done = 1'b1;
      for (int u = 0; u < NDUT; u++) begin
        if (lat[u] == 0 && out_valid_o[u]) lat[u] = c;
        if (lat[u] == 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    for (int u = 0; u < NDUT; u++) begin
      model_div(nn, dd, K_TAB[u], eq, er);
      check_val($sformatf("%s_u%0d_latency", tag, u), lat[u], LAT_TAB[u]);
      check_val($sformatf("%s_u%0d_q", tag, u), q_o[u], eq);
      check_val($sformatf("%s_u%0d_r", tag, u), r_o[u], er);
      check_val($sformatf("%s_u%0d_dbz", tag, u), dbz_o[u], (dd == 8'h00));
      check_val($sformatf("%s_u%0d_ovf", tag, u), ovf_o[u], (nn[15:8] >= dd));
      if (K_TAB[u] == 0 && dd != 8'h00 && nn[15:8] < dd) begin
        check_val($sformatf("%s_u%0d_exact_q", tag, u), q_o[u], 32'(nn / 16'(dd)));
        check_val($sformatf("%s_u%0d_exact_r", tag, u), r_o[u], 32'(nn % 16'(dd)));
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < NDUT; u++) begin
        model_div(nn, dd, K_TAB[u], eq, er);
        check_val($sformatf("%s_u%0d_hold_valid", tag, u), out_valid_o[u], 1);
        check_val($sformatf("%s_u%0d_hold_in_ready", tag, u), in_ready_o[u], 0);
        check_val($sformatf("%s_u%0d_hold_q", tag, u), q_o[u], eq);
        check_val($sformatf("%s_u%0d_hold_r", tag, u), r_o[u], er);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int u = 0; u < NDUT; u++) begin
      check_val($sformatf("%s_u%0d_valid_drop", tag, u), out_valid_o[u], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic [15:0] rn;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n         = 16'h0000;
    d         = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < NDUT; u++) begin
      check_val($sformatf("rst_u%0d_in_ready", u), in_ready_o[u], 1);
      check_val($sformatf("rst_u%0d_out_valid", u), out_valid_o[u], 0);
      check_val($sformatf("rst_u%0d_q", u), q_o[u], 0);
      check_val($sformatf("rst_u%0d_r", u), r_o[u], 0);
      check_val($sformatf("rst_u%0d_dbz", u), dbz_o[u], 0);
      check_val($sformatf("rst_u%0d_ovf", u), ovf_o[u], 0);
    end
    rst = 1'b0;

    run_op(16'd100, 8'd7, 0, "div100_7");
    check_val("div100_7_k0_q_const", q_o[0], 14);
    check_val("div100_7_k0_r_const", r_o[0], 2);
    run_op(16'd2, 8'd3, 0, "div2_3");
    check_val("div2_3_k6_q_const", q_o[1], 8'h0F);
    check_val("div2_3_k6_r_const", r_o[1], 0);
    check_val("div2_3_k0_q_const", q_o[0], 0);
    check_val("div2_3_k0_r_const", r_o[0], 2);
    run_op(16'h00FF, 8'd1, 0, "divff_1");
    check_val("divff_1_k6_q_const", q_o[1], 255);
    run_op(16'h1234, 8'd0, 0, "dbz");
    check_val("dbz_k6_r_const", r_o[1], 8'h34);
    run_op(16'h0FA0, 8'h40, 3, "hold");
    check_val("hold_r2_q_const", q_o[2], 8'h3E);
    check_val("hold_r2_r_const", r_o[2], 8'h20);

    // Reset lands on the edge that would evaluate row 4.
    n = 16'hBEEF;
    d = 8'hF1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int u = 0; u < NDUT; u++) begin
      check_val($sformatf("midrst_u%0d_in_ready", u), in_ready_o[u], 1);
      check_val($sformatf("midrst_u%0d_out_valid", u), out_valid_o[u], 0);
      check_val($sformatf("midrst_u%0d_q", u), q_o[u], 0);
      check_val($sformatf("midrst_u%0d_r", u), r_o[u], 0);
    end
    run_op(16'd100, 8'd7, 0, "after_rst");
    check_val("after_rst_k0_q_const", q_o[0], 14);
    check_val("after_rst_k0_r_const", r_o[0], 2);

    for (int t = 0; t < 40; t++) begin
      rd = 8'($urandom);
      if (t % 4 == 0) rd = 8'($urandom_range(0, 3));
      rn = 16'($urandom);
      if (t % 2 == 0 && rd != 8'h00) rn[15:8] = 8'($urandom_range(0, int'(rd) - 1));
      run_op(rn, rd, $urandom_range(0, 2), $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
